llsc_mem_ctrl: RTL and testbench

LLSC_MEM_CTRL -- requirements
Module: llsc_mem_ctrl

---
 rtl/llsc_mem_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_llsc_mem_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/llsc_mem_ctrl.sv
// llsc_mem_ctrl: LL/SC sequencer driving a single-word data bus and the external LLbit register.
// An LL reads a word and sets LLbit. An SC writes only while LLbit is still set, and returns
// 1 on success or 0 on failure.
// Optional feature: define LLSC_ADDR_CHECK_EN to also require the SC word address to match the
// last linked address.
module llsc_mem_ctrl #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              op_valid_i,
    input  logic              op_is_sc_i,
    input  logic [ADDR_W-1:0] op_addr_i,
    input  logic [31:0]       op_wdata_i,
    input  logic              LLbit_i,
    output logic              LLbit_o,
    output logic              LLbit_we_o,
    output logic              stall_req_o,
    output logic [31:0]       result_o,
    output logic              result_valid_o,
    output logic              addr_err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_sel_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_rdata_i
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

    state_e            state_q, state_d;
    logic              llbit_q, llbit_d;
    logic              llbit_we_q, llbit_we_d;
    logic [31:0]       result_q, result_d;
    logic              result_valid_q, result_valid_d;
    logic              addr_err_q, addr_err_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_sel_q, mem_sel_d;
    logic              sc_ok;
    logic              misaligned;

`ifdef LLSC_ADDR_CHECK_EN
    logic [ADDR_W-1:2] link_q, link_d;

    assign sc_ok = LLbit_i && (op_addr_i[ADDR_W-1:2] == link_q);
`else
    assign sc_ok = LLbit_i;
`endif

    assign misaligned = (op_addr_i[1:0] != 2'b00);

    // Stall is combinational so the pipeline freezes in the same cycle the op is presented.
    assign stall_req_o = ((state_q == StIdle) && op_valid_i) ||
                         (state_q == StRd) || (state_q == StWr);

    assign LLbit_o        = llbit_q;
    assign LLbit_we_o     = llbit_we_q;
    assign result_o       = result_q;
    assign result_valid_o = result_valid_q;
    assign addr_err_o     = addr_err_q;
    assign mem_req_o      = mem_req_q;
    assign mem_we_o       = mem_we_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_wdata_o    = mem_wdata_q;
    assign mem_sel_o      = mem_sel_q;

    // Next state and next registered outputs. Pulse outputs default low; bus fields hold.
    always_comb begin
        state_d        = state_q;
        llbit_d        = llbit_q;
        llbit_we_d     = 1'b0;
        result_d       = result_q;
        result_valid_d = 1'b0;
        addr_err_d     = 1'b0;
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mem_sel_d      = mem_sel_q;
`ifdef LLSC_ADDR_CHECK_EN
        link_d         = link_q;
`endif
        if (flush) begin
            // Abort. An ack arriving in this cycle is dropped.
            state_d   = StIdle;
            mem_req_d = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (op_valid_i) begin
                        if (misaligned) begin
                            state_d    = StDone;
                            addr_err_d = 1'b1;
                        end else if (!op_is_sc_i) begin
                            state_d    = StRd;
                            mem_req_d  = 1'b1;
                            mem_we_d   = 1'b0;
                            mem_sel_d  = 4'hF;
                            mem_addr_d = op_addr_i;
                        end else if (sc_ok) begin
                            state_d     = StWr;
                            mem_req_d   = 1'b1;
                            mem_we_d    = 1'b1;
                            mem_sel_d   = 4'hF;
                            mem_addr_d  = op_addr_i;
                            mem_wdata_d = op_wdata_i;
                        end else begin
                            state_d  = StDone;
                            result_d = 32'h0;
                        end
                    end
                end
                StRd: begin
                    if (mem_ack_i) begin
                        state_d    = StDone;
                        mem_req_d  = 1'b0;
                        result_d   = mem_rdata_i;
                        llbit_d    = 1'b1;
                        llbit_we_d = 1'b1;
`ifdef LLSC_ADDR_CHECK_EN
                        link_d     = mem_addr_q[ADDR_W-1:2];
`endif
                    end
                end
                StWr: begin
                    if (mem_ack_i) begin
                        state_d    = StDone;
                        mem_req_d  = 1'b0;
                        result_d   = 32'h1;
                        llbit_d    = 1'b0;
                        llbit_we_d = 1'b1;
                    end
                end
                StDone: begin
                    // addr_err_q is only high here after a misaligned op, which yields no result.
                    result_valid_d = !addr_err_q;
                    state_d        = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered outputs (and link address when enabled).
    always_ff @(posedge clk) begin
        if (!rst) begin
            llbit_q        <= 1'b0;
            llbit_we_q     <= 1'b0;
            result_q       <= 32'h0;
            result_valid_q <= 1'b0;
            addr_err_q     <= 1'b0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= 32'h0;
            mem_sel_q      <= 4'h0;
`ifdef LLSC_ADDR_CHECK_EN
            link_q         <= '0;
`endif
        end else begin
            llbit_q        <= llbit_d;
            llbit_we_q     <= llbit_we_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            addr_err_q     <= addr_err_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_sel_q      <= mem_sel_d;
`ifdef LLSC_ADDR_CHECK_EN
            link_q         <= link_d;
`endif
        end
    end

endmodule

// File: tb/tb_llsc_mem_ctrl.sv
// Bench for llsc_mem_ctrl: directed LL/SC/flush/reset scenarios, then random ops.
// The expected values come from a transaction-level LL/SC model. The bench acts as bus slave
// and owns the LLbit register.
module tb_llsc_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        op_valid_i = 1'b0;
    logic        op_is_sc_i = 1'b0;
    logic [31:0] op_addr_i = 32'h0;
    logic [31:0] op_wdata_i = 32'h0;
    logic        llbit_reg = 1'b0;
    logic        LLbit_o, LLbit_we_o, stall_req_o, result_valid_o, addr_err_o;
    logic [31:0] result_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_sel_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'h0;

    int n_pass = 0;
    int n_total = 0;

    // Reference model state.
    logic [31:0] mem [logic [31:0]];
    bit          mdl_llbit = 1'b0;
    logic [31:0] mdl_link = 32'h0;

    llsc_mem_ctrl #(.ADDR_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .op_valid_i     (op_valid_i),
        .op_is_sc_i     (op_is_sc_i),
        .op_addr_i      (op_addr_i),
        .op_wdata_i     (op_wdata_i),
        .LLbit_i        (llbit_reg),
        .LLbit_o        (LLbit_o),
        .LLbit_we_o     (LLbit_we_o),
        .stall_req_o    (stall_req_o),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .addr_err_o     (addr_err_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_sel_o      (mem_sel_o),
        .mem_ack_i      (mem_ack_i),
        .mem_rdata_i    (mem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, 32'({mem_req_o, mem_we_o, mem_sel_o, LLbit_o, LLbit_we_o,
                                  result_valid_o, addr_err_o}), 32'h0);
        check({tag, "_res"}, result_o, 32'h0);
        check({tag, "_addr"}, mem_addr_o, 32'h0);
        check({tag, "_wdata"}, mem_wdata_o, 32'h0);
    endtask

    // One op presented for a single cycle at a negedge; the slave acks on the d-th request cycle.
    task automatic run_op(input bit is_sc, input logic [31:0] addr, input logic [31:0] wdata,
                          input int d);
        bit mis, bus, sc_ok;
        logic [31:0] exp_res, b_addr, b_wdata, res_seen;
        logic b_we, we_val, stall_done;
        logic [3:0] b_sel;
        int exp_lat, done_cyc, n_win;
        int req_cyc, we_cnt, val_cnt, err_cnt, val_cyc, unstable, stall_bad;
        mis = (addr[1:0] != 2'b00);
        sc_ok = mdl_llbit;
`ifdef LLSC_ADDR_CHECK_EN
        if (addr[31:2] != mdl_link[31:2]) sc_ok = 1'b0;
`endif
        bus = !mis && (!is_sc || sc_ok);
        exp_res = is_sc ? (bus ? 32'h1 : 32'h0) : (mis ? 32'h0 : mem_rd(addr));
        exp_lat = bus ? d + 2 : 2;
        done_cyc = mis ? 1 : exp_lat - 1;
        n_win = d + 5;
        req_cyc = 0; we_cnt = 0; val_cnt = 0; err_cnt = 0; val_cyc = 0;
        unstable = 0; stall_bad = 0; stall_done = 1'b1; we_val = 1'b0; res_seen = 32'h0;
        b_addr = 32'h0; b_wdata = 32'h0; b_we = 1'b0; b_sel = 4'h0;

        op_valid_i = 1'b1; op_is_sc_i = is_sc; op_addr_i = addr; op_wdata_i = wdata;
        #1 check("stall_accept", 32'(stall_req_o), 32'h1);
        @(posedge clk);
        for (int cyc = 1; cyc <= n_win; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                op_valid_i = 1'b0; op_addr_i = $urandom; op_wdata_i = $urandom;
                op_is_sc_i = 1'($urandom);
            end
            #1;
            if (mem_req_o) begin
                req_cyc++;
                if (!stall_req_o) stall_bad++;
                if (req_cyc == 1) begin
                    b_addr = mem_addr_o; b_wdata = mem_wdata_o; b_we = mem_we_o; b_sel = mem_sel_o;
                end else if (b_addr !== mem_addr_o || b_wdata !== mem_wdata_o ||
                             b_we !== mem_we_o || b_sel !== mem_sel_o) begin
                    unstable++;
                end
            end
            if (mem_req_o && req_cyc == d) begin
                mem_ack_i = 1'b1;
                mem_rdata_i = mem_rd(mem_addr_o);
                if (mem_we_o) mem[mem_addr_o] = mem_wdata_o;
            end else begin
                mem_ack_i = 1'b0;
                mem_rdata_i = $urandom;
            end
            if (LLbit_we_o) begin
                we_cnt++; we_val = LLbit_o; llbit_reg = LLbit_o;
            end
            if (result_valid_o) begin
                val_cnt++;
                if (val_cnt == 1) begin
                    val_cyc = cyc; res_seen = result_o;
                end
            end
            if (addr_err_o) err_cnt++;
            if (cyc == done_cyc) stall_done = stall_req_o;
        end
        mem_ack_i = 1'b0;

        check("bus_used", 32'(req_cyc != 0), 32'(bus));
        if (bus) begin
            check("bus_addr", b_addr, addr);
            check("bus_we", 32'(b_we), 32'(is_sc));
            check("bus_sel", 32'(b_sel), 32'hF);
            if (is_sc) check("bus_wdata", b_wdata, wdata);
            check("bus_len", 32'(req_cyc), 32'(d));
            check("bus_stable", 32'(unstable), 32'h0);
            check("llbit_val", 32'(we_val), is_sc ? 32'h0 : 32'h1);
        end
        check("llbit_we_cnt", 32'(we_cnt), 32'(bus));
        check("addr_err_cnt", 32'(err_cnt), 32'(mis));
        check("valid_cnt", 32'(val_cnt), mis ? 32'h0 : 32'h1);
        if (!mis) begin
            check("result", res_seen, exp_res);
            check("latency", 32'(val_cyc), 32'(exp_lat));
        end
        check("stall_done", 32'(stall_done), 32'h0);
        check("stall_busy", 32'(stall_bad), 32'h0);

        if (!mis) begin
            if (!is_sc) begin
                mdl_llbit = 1'b1; mdl_link = addr;
            end else if (bus) begin
                mdl_llbit = 1'b0;
            end
        end
    endtask

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("rst");
        check("rst_stall", 32'(stall_req_o), 32'h0);
        rst = 1'b1;

        // LL with 2-cycle ack, then a matching SC, then an SC with LLbit clear.
        mem[32'h100] = 32'hDEADBEEF;
        run_op(1'b0, 32'h100, 32'h0, 2);
        check("llbit_reg_set", 32'(llbit_reg), 32'h1);
        run_op(1'b1, 32'h100, 32'h55, 1);
        check("mem_written", mem[32'h100], 32'h55);
        llbit_reg = 1'b0; mdl_llbit = 1'b0;
        run_op(1'b1, 32'h100, 32'h77, 1);
        check("mem_kept", mem[32'h100], 32'h55);

`ifdef LLSC_ADDR_CHECK_EN
        run_op(1'b0, 32'h100, 32'h0, 1);
        run_op(1'b1, 32'h104, 32'h99, 1);
`endif
        run_op(1'b0, 32'h102, 32'h0, 1);

        // Flush in RD together with the ack: no result, no LLbit write.
        op_valid_i = 1'b1; op_is_sc_i = 1'b0; op_addr_i = 32'h108;
        @(posedge clk);
        @(negedge clk);
        op_valid_i = 1'b0;
        #1 check("flush_rd_req", 32'(mem_req_o), 32'h1);
        flush = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0; mem_ack_i = 1'b0;
        #1;
        check("flush_req", 32'(mem_req_o), 32'h0);
        check("flush_stall", 32'(stall_req_o), 32'h0);
        begin
            int bad = 0;
            for (int i = 0; i < 3; i++) begin
                if (result_valid_o || LLbit_we_o) bad++;
                @(negedge clk);
                #1;
            end
            check("flush_quiet", 32'(bad), 32'h0);
        end
        @(negedge clk);

        // Reset while an SC write is outstanding.
        run_op(1'b0, 32'h10C, 32'h0, 1);
        op_valid_i = 1'b1; op_is_sc_i = 1'b1; op_addr_i = 32'h10C; op_wdata_i = 32'hCAFE;
        @(posedge clk);
        @(negedge clk);
        op_valid_i = 1'b0;
        #1 check("wr_req", 32'({mem_req_o, mem_we_o}), 32'h3);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("rst_wr");
        check("rst_wr_stall", 32'(stall_req_o), 32'h0);
        llbit_reg = 1'b0; mdl_llbit = 1'b0; mdl_link = 32'h0;
        @(negedge clk);

        // Random ops over a small address window so SCs often hit the linked word.
        for (int k = 0; k < 40; k++) begin
            logic [31:0] a;
            a = 32'h100 + 32'(4 * $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 5) == 0) begin
                llbit_reg = 1'b0; mdl_llbit = 1'b0;
            end
            run_op(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(1, 4));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
